// File: rtl/fir_tap_buffer_mb.sv
// Multi-bank FIR coefficient buffer: serial taps in, one completed bank out as a single wide beat.
// Latency: a bank is presented the cycle after its last serial beat is accepted; swaps are gap-free.
// Backpressure: h_serial_ready drops while the target bank is full; a presented bank holds until released.
//
// Ports:
//   clk_i, rst_i, clear_i       clock, synchronous active-high reset and soft clear (same effect)
//   nb_taps_i, sticky_i         tap count of the next bank to load (0 or >MAX_TAPS -> MAX_TAPS), read mode
//   h_serial_*                  serial tap stream sink (strb ignored)
//   h_parallel_*                wide tap stream source, lane k = tap k, lanes >= len forced to 0
//   nb_taps_o                   tap count of the bank currently presented, 0 when none
module fir_tap_buffer_mb #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_TAPS   = 64,
  parameter int NB_BANKS   = 2,
  localparam int TW = $clog2(MAX_TAPS + 1),
  localparam int PW = DATA_WIDTH * MAX_TAPS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [TW-1:0]           nb_taps_i,
  input  logic                    sticky_i,
  input  logic                    h_serial_valid,
  output logic                    h_serial_ready,
  input  logic [DATA_WIDTH-1:0]   h_serial_data,
  input  logic [DATA_WIDTH/8-1:0] h_serial_strb,
  output logic                    h_parallel_valid,
  input  logic                    h_parallel_ready,
  output logic [PW-1:0]           h_parallel_data,
  output logic [PW/8-1:0]         h_parallel_strb,
  output logic [TW-1:0]           nb_taps_o
);

  localparam int IW = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
  localparam int BW = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;

  typedef enum logic {IDLE, LOAD} wr_state_t;

  wr_state_t             state, state_nxt;
  logic [DATA_WIDTH-1:0] taps [NB_BANKS][MAX_TAPS];
  logic [TW-1:0]         len  [NB_BANKS];
  logic [NB_BANKS-1:0]   full;
  logic [NB_BANKS-1:0]   set_mask, rel_mask;
  logic [BW-1:0]         wr_bank, wr_bank_nxt;
  logic [BW-1:0]         rd_bank, rd_bank_nxt;
  logic [IW-1:0]         wr_idx, wr_addr;
  logic [TW-1:0]         nb_clamped, cur_len;
  logic                  srst, s_hs, p_hs, wr_last, rel, sticky_eff;
  logic                  wr_en, len_we, set_full;
  logic                  strb_unused;

  assign srst        = rst_i | clear_i;
  assign strb_unused = ^h_serial_strb;

  assign nb_clamped = ((nb_taps_i == '0) || (nb_taps_i > TW'(MAX_TAPS))) ? TW'(MAX_TAPS) : nb_taps_i;

  assign wr_bank_nxt = (wr_bank == BW'(NB_BANKS - 1)) ? '0 : wr_bank + 1'b1;
  assign rd_bank_nxt = (rd_bank == BW'(NB_BANKS - 1)) ? '0 : rd_bank + 1'b1;

  // Ready depends on registered fullness only, so a bank released this cycle
  // cannot be refilled until the next one. Held low while reset/clear is high.
  assign h_serial_ready = ~full[wr_bank] & ~srst;
  assign s_hs           = h_serial_valid & h_serial_ready;

  // Length governing the current beat: on the first beat it is the fresh
  // clamped request, afterwards the value latched for this bank. wr_idx is 0
  // in IDLE, so a 1-tap load completes on its first beat.
  assign cur_len = (state == IDLE) ? nb_clamped : len[wr_bank];
  assign wr_last = (TW'(wr_idx) == (cur_len - 1'b1));

  // Write-side FSM: state register
  always_ff @(posedge clk_i) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Write-side FSM: next state
  always_comb begin
    state_nxt = state;
    if (s_hs) state_nxt = wr_last ? IDLE : LOAD;
  end

  // Write-side FSM: outputs
  always_comb begin
    wr_en    = s_hs;
    wr_addr  = wr_idx;
    len_we   = s_hs && (state == IDLE);
    set_full = s_hs & wr_last;
  end

  // Read side. In sticky mode a bank is only released once its successor is
  // full; the check uses registered fullness, so a bank completing in this
  // same cycle takes over on the following handshake.
  assign sticky_eff       = (NB_BANKS > 1) && sticky_i;
  assign h_parallel_valid = full[rd_bank];
  assign p_hs             = h_parallel_valid & h_parallel_ready;
  assign rel              = p_hs & (~sticky_eff | full[rd_bank_nxt]);

  // A set targets an empty bank and a release a full one, so the masks
  // never hit the same bank in one cycle.
  assign set_mask = NB_BANKS'(set_full) << wr_bank;
  assign rel_mask = NB_BANKS'(rel) << rd_bank;

  always_ff @(posedge clk_i) begin
    if (srst) begin
      full    <= '0;
      wr_bank <= '0;
      rd_bank <= '0;
      wr_idx  <= '0;
      for (int b = 0; b < NB_BANKS; b++) len[b] <= '0;
    end else begin
      if (len_we)   len[wr_bank] <= nb_clamped;
      if (s_hs)     wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
      if (set_full) wr_bank <= wr_bank_nxt;
      if (rel)      rd_bank <= rd_bank_nxt;
      full <= (full & ~rel_mask) | set_mask;
    end
  end

  // Tap storage needs no reset: lanes beyond len are masked on the output.
  always_ff @(posedge clk_i) begin
    if (wr_en) taps[wr_bank][wr_addr] <= h_serial_data;
  end

  for (genvar i = 0; i < MAX_TAPS; i++) begin : g_lane
    assign h_parallel_data[i*DATA_WIDTH +: DATA_WIDTH] =
      (TW'(i) < len[rd_bank]) ? taps[rd_bank][i] : '0;
  end

  assign h_parallel_strb = '1;
  assign nb_taps_o       = full[rd_bank] ? len[rd_bank] : '0;

endmodule

// File: tb/tb_fir_tap_buffer_mb.sv
// Bench for fir_tap_buffer_mb (default parameters: 16-bit taps, 64 lanes, 2 banks).
// Table of single-bank loads with hand-computed lane contents, then directed
// sequences for bank stall, sticky swap and reset during a load.
module tb_fir_tap_buffer_mb;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [6:0]    nb_in = '0;
  logic          sticky = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [15:0]   s_data = '0;
  logic          p_valid;
  logic          p_ready = 1'b0;
  logic [1023:0] p_data;
  logic [127:0]  p_strb;
  logic [6:0]    p_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_tap_buffer_mb dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_i         (clear),
    .nb_taps_i       (nb_in),
    .sticky_i        (sticky),
    .h_serial_valid  (s_valid),
    .h_serial_ready  (s_ready),
    .h_serial_data   (s_data),
    .h_serial_strb   (2'b11),
    .h_parallel_valid(p_valid),
    .h_parallel_ready(p_ready),
    .h_parallel_data (p_data),
    .h_parallel_strb (p_strb),
    .nb_taps_o       (p_nb)
  );

  typedef struct {
    logic [6:0]  nb_in;
    logic [15:0] base;
    int          exp_len;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Expected bank: lane k = base + k for k < n, every other lane 0.
  task automatic chk_data(input string name, input logic [15:0] base, input int n);
    int          bad;
    logic [15:0] e, a, eb, ab;
    bad = -1;
    eb  = '0;
    ab  = '0;
    checks++;
    for (int i = 0; i < 64; i++) begin
      e = (i < n) ? base + 16'(i) : 16'h0000;
      a = p_data[i*16 +: 16];
      if (a !== e && bad < 0) begin
        bad = i;
        eb  = e;
        ab  = a;
      end
    end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s lane %0d got %h want %h", name, bad, ab, eb);
    end
  endtask

  // One serial beat; starts and ends on a falling edge, so consecutive calls
  // give one accepted beat per cycle.
  task automatic push(input logic [15:0] d);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout data %h got ready 0 want 1", d);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_reset(input bit use_clear);
    if (use_clear) clear = 1'b1;
    else           rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk(use_clear ? "clear_ready" : "rst_ready", int'(s_ready), 0);
    rst   = 1'b0;
    clear = 1'b0;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_cnt;

    vecs[0] = '{7'd4,  16'h0001, 4};
    vecs[1] = '{7'd0,  16'h1000, 64};
    vecs[2] = '{7'd70, 16'h2000, 64};
    vecs[3] = '{7'd1,  16'h3000, 1};
    vecs[4] = '{7'd8,  16'h4000, 8};   // lands in the bank that held vecs[2]
    vecs[5] = '{7'd64, 16'h5000, 64};
    vecs[6] = '{7'd3,  16'h6000, 3};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_ready", int'(s_ready), 0);
    chk("reset_valid", int'(p_valid), 0);
    chk("reset_nb", int'(p_nb), 0);
    chk_data("reset_data", 16'h0000, 0);
    chk("strb_ones", int'(p_strb == '1), 1);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", int'(s_ready), 1);

    // Table of ONE_SHOT loads
    for (int v = 0; v < 7; v++) begin
      nb_in   = vecs[v].nb_in;
      sticky  = 1'b0;
      p_ready = 1'b0;
      for (int k = 0; k < vecs[v].exp_len - 1; k++) push(vecs[v].base + 16'(k));
      chk($sformatf("v%0d_early_valid", v), int'(p_valid), 0);
      push(vecs[v].base + 16'(vecs[v].exp_len - 1));
      chk($sformatf("v%0d_valid", v), int'(p_valid), 1);
      chk($sformatf("v%0d_nb", v), int'(p_nb), vecs[v].exp_len);
      chk_data($sformatf("v%0d_data", v), vecs[v].base, vecs[v].exp_len);
      @(negedge clk);
      chk($sformatf("v%0d_hold_valid", v), int'(p_valid), 1);
      chk_data($sformatf("v%0d_hold_data", v), vecs[v].base, vecs[v].exp_len);
      p_ready = 1'b1;
      @(negedge clk);
      p_ready = 1'b0;
      chk($sformatf("v%0d_release_valid", v), int'(p_valid), 0);
      chk($sformatf("v%0d_release_nb", v), int'(p_nb), 0);
    end

    // Both banks full: third load stalls until one handshake
    do_reset(1'b0);
    sticky  = 1'b0;
    p_ready = 1'b0;
    nb_in   = 7'd8;
    for (int k = 0; k < 8; k++) push(16'h7100 + 16'(k));
    for (int k = 0; k < 8; k++) push(16'h7200 + 16'(k));
    #1;
    chk("stall_ready", int'(s_ready), 0);
    chk("stall_valid", int'(p_valid), 1);
    chk_data("stall_first_bank", 16'h7100, 8);
    p_ready = 1'b1;
    #1;
    chk("stall_no_bypass", int'(s_ready), 0);
    @(negedge clk);
    p_ready = 1'b0;
    #1;
    chk("stall_ready_after_release", int'(s_ready), 1);
    chk_data("stall_second_bank", 16'h7200, 8);
    for (int k = 0; k < 8; k++) push(16'h7300 + 16'(k));
    chk_data("stall_second_still", 16'h7200, 8);
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
    chk("stall_third_nb", int'(p_nb), 8);
    chk_data("stall_third_bank", 16'h7300, 8);

    // STICKY: A re-presented, then zero-gap swap to B
    do_reset(1'b1);
    sticky  = 1'b1;
    p_ready = 1'b1;
    nb_in   = 7'd10;
    for (int k = 0; k < 10; k++) push(16'h8000 + 16'(k));
    a_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (p_valid && p_nb == 7'd10 && p_data[15:0] == 16'h8000) a_cnt++;
      @(negedge clk);
    end
    chk("sticky_a_presented", a_cnt, 20);
    nb_in = 7'd5;
    a_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      push(16'h9000 + 16'(k));
      if (p_valid && p_nb == 7'd10 && p_data[15:0] == 16'h8000) a_cnt++;
    end
    chk("sticky_a_during_b_load", a_cnt, 5);
    @(negedge clk);
    chk("sticky_swap_valid", int'(p_valid), 1);
    chk("sticky_swap_nb", int'(p_nb), 5);
    chk_data("sticky_swap_data", 16'h9000, 5);
    @(negedge clk);
    chk("sticky_b_repeat_nb", int'(p_nb), 5);
    chk("sticky_b_repeat_ready", int'(s_ready), 1);
    p_ready = 1'b0;
    sticky  = 1'b0;

    // Reset after 3 of 6 beats discards the partial bank
    do_reset(1'b0);
    nb_in = 7'd6;
    for (int k = 0; k < 3; k++) push(16'hA000 + 16'(k));
    rst = 1'b1;
    #1;
    chk("midrst_ready", int'(s_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_valid", int'(p_valid), 0);
    chk("midrst_nb", int'(p_nb), 0);
    for (int k = 0; k < 5; k++) push(16'hB000 + 16'(k));
    chk("midrst_early_valid", int'(p_valid), 0);
    push(16'hB005);
    chk("midrst_reload_valid", int'(p_valid), 1);
    chk("midrst_reload_nb", int'(p_nb), 6);
    chk_data("midrst_reload_data", 16'hB000, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_tap_buffer_mb.md
# fir_tap_buffer_mb

Multi-bank, runtime-length FIR coefficient buffer: deserialises a serial HWPE-Stream of taps into one of NB_BANKS register banks and presents a completed bank as a single wide HWPE-Stream beat to the FIR datapath. It replaces the single-bank tap buffer between the coefficient source and `fir_datapath`. Double buffering lets new coefficients load while the datapath keeps consuming the current set, with gap-free swap.

## Interface
- DATA_WIDTH, 16, width of one tap.
- MAX_TAPS, 64, bank depth and h_parallel lane count.
- NB_BANKS, 2, number of banks (≥1); TW = $clog2(MAX_TAPS+1).
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- nb_taps_i  in  TW  tap count for the next bank to load; 0 or >MAX_TAPS clamps to MAX_TAPS.
- sticky_i  in  1  0 = ONE_SHOT, 1 = STICKY (ignored if NB_BANKS==1).
- h_serial  sink  DATA_WIDTH  hwpe_stream_intf_stream; strb ignored.
- h_parallel  source  DATA_WIDTH*MAX_TAPS  hwpe_stream_intf_stream; strb all ones.
- nb_taps_o  out  TW  tap count of the bank currently presented (0 if none).

## Operation
- State per bank b: taps[b][0..MAX_TAPS-1], len[b] (TW), full[b]. Pointers wr_bank, rd_bank, wr_idx.
- Write side, states IDLE / LOAD:
  - IDLE: wr_idx==0. First accepted beat latches the clamped nb_taps_i into len[wr_bank] and goes to LOAD, or directly FULL-marks if len==1.
  - Beat k of a load goes to taps[wr_bank][k], i.e. lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
  - On beat len-1: full[wr_bank]<=1, wr_bank<=(wr_bank+1) mod NB_BANKS, wr_idx<=0, back to IDLE.
  - h_serial.ready = ~full[wr_bank] (registered state only, no same-cycle bypass of a release).
- Read side:
  - h_parallel.valid = full[rd_bank].
  - h_parallel.data lane i = taps[rd_bank][i] for i<len[rd_bank], else 0. Stale words beyond len are never visible.
  - nb_taps_o = full[rd_bank] ? len[rd_bank] : 0.
- Release on h_parallel handshake (valid & ready):
  - ONE_SHOT: full[rd_bank]<=0, rd_bank advances.
  - STICKY: release/advance only if full[next rd_bank]; otherwise the same bank is re-presented indefinitely.
- Simultaneous last-write beat and handshake in the same cycle:
  - The release decision uses full[] before the write takes effect.
  - In STICKY, the new bank is used from the next handshake on.
- Reset or clear mid-load: partial bank discarded, all full<=0, pointers to 0, len<=0, taps contents need not be cleared.

## Timing
- Reset values: h_serial.ready=0 while rst_i/clear_i is asserted, 1 in the first cycle after. h_parallel.valid=0, h_parallel.data=0, nb_taps_o=0.
- Load latency: h_parallel.valid rises the cycle after the last h_serial handshake of a bank.
- Throughput: 1 serial beat/cycle while the target bank is empty.
- NB_BANKS==1: the next load stalls until release. ready rises the cycle after the release handshake (one bubble).
- STICKY swap: zero-gap. The first handshake after the next bank fills releases the old bank, and the next cycle presents the new bank.
- Valid is never withdrawn without a handshake. Data and nb_taps_o stay stable while valid & ~ready.

## Test plan
- Reset, then nb_taps_i=4, serial 1,2,3,4 -> one cycle later valid=1, lanes 0..3 = 1,2,3,4, lanes 4..63 = 0, nb_taps_o=4. ONE_SHOT handshake -> valid=0 next cycle.
- NB_BANKS=2, ONE_SHOT, h_parallel.ready=0: load 3 banks of 8 taps -> third load stalls (ready=0) after 16 beats. One handshake -> ready=1 next cycle and the third bank completes.
- STICKY, bank A (taps=10) consumed with ready=1 for 20 cycles -> A presented 20 times. Load bank B (taps=5) -> first handshake after B full still shows A, next cycle shows B with nb_taps_o=5, no valid gap.
- nb_taps_i=0 and nb_taps_i=70 -> each load takes 64 beats, nb_taps_o=64.
- Load bank of 64 taps, then 8 taps into the same bank position -> lanes 8..63 read 0, not stale values.
- rst_i pulse after 3 of 6 beats -> valid stays 0. A subsequent full 6-beat load produces the correct bank from lane 0.
